// File: rtl/datapath_control_unit.sv
// Instruction sequencer: fetches 3-byte instructions over a req/valid read port and drives
// register-load, ALU-select and writeback strobes into the datapath.
module datapath_control_unit #(
    parameter int unsigned           ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [7:0]            HALT_OPCODE = 8'hFF,
    parameter logic [7:0]            NOP_OPCODE  = 8'h00,
    parameter int unsigned           EXEC_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_valid,
    output logic [7:0]            alu_op,
    output logic [7:0]            operando1,
    output logic [7:0]            operando2,
    output logic                  reg_load_a,
    output logic                  reg_load_b,
    output logic                  reg_load_c,
    output logic                  instr_done,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetchOp,
        StFetchA,
        StFetchB,
        StLoad,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;
    logic [7:0]            alu_op_q, alu_op_d;
    logic [7:0]            opnd1_q, opnd1_d;
    logic [7:0]            opnd2_q, opnd2_d;
    logic                  load_ab_q, load_ab_d;
    logic                  load_c_q, load_c_d;
    logic                  halted_q, halted_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  byte_ok;

    // Data is only accepted while a request is outstanding.
    assign byte_ok = mem_rd_q & mem_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        alu_op_d = alu_op_q;
        opnd1_d  = opnd1_q;
        opnd2_d  = opnd2_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                if (start) state_d = StFetchOp;
            end
            StFetchOp: begin
                if (byte_ok) begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                    if (mem_rdata == HALT_OPCODE) begin
                        state_d = StHalt;
                    end else if (mem_rdata == NOP_OPCODE) begin
                        state_d = StFetchOp;
                    end else begin
                        alu_op_d = mem_rdata;
                        state_d  = StFetchA;
                    end
                end
            end
            StFetchA: begin
                if (byte_ok) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    opnd1_d = mem_rdata;
                    state_d = StFetchB;
                end
            end
            StFetchB: begin
                if (byte_ok) begin
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    opnd2_d = mem_rdata;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StExec;
            end
            StExec: begin
                if (cnt_q == EXEC_LAST) state_d = StWb;
                else                    cnt_d   = cnt_q + 4'd1;
            end
            StWb: begin
                state_d = StFetchOp;
            end
            StHalt: begin
                if (start) state_d = StFetchOp;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet state-aligned.
        mem_rd_d   = (state_d == StFetchOp) || (state_d == StFetchA) || (state_d == StFetchB);
        mem_addr_d = mem_rd_d ? pc_d : '0;
        load_ab_d  = (state_d == StLoad);
        load_c_d   = (state_d == StWb);
        halted_d   = (state_d == StHalt);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            alu_op_q   <= '0;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            load_ab_q  <= 1'b0;
            load_c_q   <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            alu_op_q   <= alu_op_d;
            opnd1_q    <= opnd1_d;
            opnd2_q    <= opnd2_d;
            load_ab_q  <= load_ab_d;
            load_c_q   <= load_c_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign alu_op     = alu_op_q;
    assign operando1  = opnd1_q;
    assign operando2  = opnd2_q;
    assign reg_load_a = load_ab_q;
    assign reg_load_b = load_ab_q;
    assign reg_load_c = load_c_q;
    assign instr_done = load_c_q;
    assign halted     = halted_q;
    assign pc         = pc_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Directed bench for datapath_control_unit: table-driven program run plus hand-written
// sequences for wait states, NOPs, halt/resume, pc wrap and mid-fetch reset.
module tb_datapath_control_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_valid;
    logic [7:0] alu_op, operando1, operando2;
    logic       reg_load_a, reg_load_b, reg_load_c, instr_done, halted;
    logic [7:0] pc;

    datapath_control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .alu_op     (alu_op),
        .operando1  (operando1),
        .operando2  (operando2),
        .reg_load_a (reg_load_a),
        .reg_load_b (reg_load_b),
        .reg_load_c (reg_load_c),
        .instr_done (instr_done),
        .halted     (halted),
        .pc         (pc)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [256];
    int         mem_wait = 0;
    int         wcnt = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         excl_bad = 0;

    // Memory model: answers after mem_wait idle cycles per requested byte.
    initial begin
        mem_valid = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clock);
            #1;
            if (mem_rd) begin
                if (wcnt >= mem_wait) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem[mem_addr];
                    wcnt = 0;
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = 8'hEE;
                    wcnt++;
                end
            end else begin
                mem_valid = 1'b0;
                wcnt = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (reg_load_c && (reg_load_a || reg_load_b)) excl_bad++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    // Returns at cycle 1 (first cycle in FETCH_OP).
    task automatic start_run();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic fill_mem(input logic [7:0] val);
        for (int i = 0; i < 256; i++) mem[i] = val;
    endtask

    typedef struct {
        logic [7:0] op, a, b;
        logic [7:0] exp_alu, exp_o1, exp_o2, exp_pc;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        int cnt;
        reset = 1'b0;
        start = 1'b0;

        vecs[0] = '{8'h01, 8'h05, 8'h03, 8'h01, 8'h05, 8'h03, 8'd3};
        vecs[1] = '{8'h7A, 8'hC3, 8'h11, 8'h7A, 8'hC3, 8'h11, 8'd6};
        vecs[2] = '{8'h02, 8'h00, 8'hFF, 8'h02, 8'h00, 8'hFF, 8'd9};
        vecs[3] = '{8'h80, 8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'd12};

        // Reset values, checked while reset is held low.
        fill_mem(8'hFF);
        repeat (2) @(negedge clock);
        chk("rst mem_rd", 32'(mem_rd), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst alu_op", 32'(alu_op), 0);
        chk("rst operands", {16'h0, operando1, operando2}, 0);
        chk("rst strobes", {28'h0, reg_load_a, reg_load_b, reg_load_c, instr_done}, 0);
        chk("rst halted", 32'(halted), 0);
        chk("rst pc", 32'(pc), 0);

        // Table-driven program, zero-wait memory, halt byte after the last instruction.
        for (int k = 0; k < 4; k++) begin
            mem[3*k]   = vecs[k].op;
            mem[3*k+1] = vecs[k].a;
            mem[3*k+2] = vecs[k].b;
        end
        mem_wait = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("idle no fetch", 32'(mem_rd), 0);
        start_run();
        chk("c1 mem_rd", 32'(mem_rd), 1);
        chk("c1 mem_addr", 32'(mem_addr), 0);
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clock);
            chk("load strobes", {29'h0, reg_load_a, reg_load_b, reg_load_c}, 32'b110);
            chk("load alu_op", 32'(alu_op), 32'(vecs[k].exp_alu));
            chk("load operando1", 32'(operando1), 32'(vecs[k].exp_o1));
            chk("load operando2", 32'(operando2), 32'(vecs[k].exp_o2));
            chk("load pc", 32'(pc), 32'(vecs[k].exp_pc));
            repeat (2) @(negedge clock);
            chk("wb strobes", {28'h0, reg_load_a, reg_load_b, reg_load_c, instr_done},
                32'b0011);
            @(negedge clock);
            chk("next fetch addr", {23'h0, mem_rd, mem_addr}, {23'h0, 1'b1, vecs[k].exp_pc});
        end
        @(negedge clock);
        chk("end halted", {23'h0, halted, pc}, {23'h0, 1'b1, 8'd13});
        chk("end halt mem_rd", 32'(mem_rd), 0);

        // Wait states: 3 idle cycles per byte.
        do_reset();
        fill_mem(8'hFF);
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h03;
        mem_wait = 3;
        start_run();
        for (int i = 1; i <= 4; i++) begin
            chk("wait hold", {14'h0, mem_rd, mem_addr, pc, alu_op}, {14'h0, 1'b1, 24'h000000});
            if (i < 4) @(negedge clock);
        end
        @(negedge clock);
        chk("wait byte0 capt", {mem_addr, pc, alu_op, operando1}, 32'h01010100);
        cyc = 5;
        while (!reg_load_a && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        chk("wait load cycle", 32'(cyc), 13);
        chk("wait operands", {8'h0, alu_op, operando1, operando2}, 32'h00010503);
        chk("wait pc", 32'(pc), 3);

        // Two NOPs then one instruction.
        do_reset();
        fill_mem(8'hFF);
        mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'h02; mem[3] = 8'h0A; mem[4] = 8'h0B;
        mem_wait = 0;
        start_run();
        cnt = 0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            if (reg_load_a || reg_load_b || reg_load_c || instr_done) cnt++;
            if (c == 3) chk("nop addr", {mem_addr, pc, alu_op}, 24'h020200);
        end
        chk("nop no strobes", 32'(cnt), 0);
        @(negedge clock);
        chk("nop load", {7'h0, reg_load_a, alu_op, operando1, operando2}, 32'h01020A0B);
        chk("nop pc", 32'(pc), 5);
        repeat (2) @(negedge clock);
        chk("nop done", 32'(instr_done), 1);
        repeat (2) @(negedge clock);
        chk("nop then halt", {23'h0, halted, pc}, {23'h0, 1'b1, 8'd6});

        // Halt then resume.
        do_reset();
        fill_mem(8'hFF);
        mem[1] = 8'h01; mem[2] = 8'h22; mem[3] = 8'h33;
        start_run();
        @(negedge clock);
        chk("halt state", {22'h0, halted, mem_rd, pc}, {22'h0, 2'b10, 8'd1});
        chk("halt alu_op kept", 32'(alu_op), 0);
        cnt = 0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clock);
            if (reg_load_a || reg_load_b || reg_load_c || instr_done || mem_rd) cnt++;
        end
        chk("halt quiet", 32'(cnt), 0);
        chk("halt hold", {23'h0, halted, pc}, {23'h0, 1'b1, 8'd1});
        start_run();
        chk("resume fetch", {22'h0, halted, mem_rd, mem_addr}, {22'h0, 2'b01, 8'd1});
        repeat (3) @(negedge clock);
        chk("resume load", {7'h0, reg_load_a, alu_op, operando1, operando2}, 32'h01012233);
        chk("resume pc", 32'(pc), 4);

        // pc wrap: 85th instruction sits at FE/FF/00.
        do_reset();
        fill_mem(8'h01);
        mem[0] = 8'h5A; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h00; mem[4] = 8'h00;
        mem[254] = 8'h3C; mem[255] = 8'h77;
        start_run();
        cyc = 0;
        cnt = 0;
        while (cnt < 85 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            if (reg_load_a) cnt++;
        end
        chk("wrap reached", 32'(cnt), 85);
        chk("wrap operands", {8'h0, alu_op, operando1, operando2}, 32'h003C775A);
        chk("wrap pc", 32'(pc), 1);

        // Asynchronous reset during the FETCH_B wait.
        do_reset();
        fill_mem(8'hFF);
        mem[0] = 8'h01; mem[1] = 8'h05; mem[2] = 8'h03;
        mem_wait = 3;
        start_run();
        repeat (9) @(negedge clock);
        chk("fb wait", {23'h0, mem_rd, mem_addr}, {23'h0, 1'b1, 8'd2});
        #2;
        reset = 1'b0;
        #1;
        chk("async rst rd", {23'h0, mem_rd, mem_addr}, 0);
        chk("async rst regs", {alu_op, operando1, operando2, pc}, 0);
        chk("async rst flags", {28'h0, reg_load_a, reg_load_c, instr_done, halted}, 0);
        @(negedge clock);
        reset = 1'b1;
        mem_wait = 0;
        repeat (2) @(negedge clock);
        chk("post rst idle", 32'(mem_rd), 0);
        start_run();
        chk("restart addr", {23'h0, mem_rd, mem_addr}, {23'h0, 1'b1, 8'd0});
        repeat (3) @(negedge clock);
        chk("restart load", {7'h0, reg_load_a, alu_op, operando1, operando2}, 32'h01010503);
        chk("restart pc", 32'(pc), 3);

        chk("strobe exclusive", 32'(excl_bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
